// File: rtl/iter_factorial_unit_if.sv
// Job channel and result channel of the iterative factorial engine, both valid/ready.
interface iter_factorial_unit_if #(
  parameter int N_WIDTH = 8,
  parameter int WIDTH   = 8
);
  logic [N_WIDTH-1:0] in_n;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   out_result;
  logic               out_overflow;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  modport master (
    output in_n, in_valid, out_ready,
    input  in_ready, out_result, out_overflow, out_valid, busy
  );

  modport slave (
    input  in_n, in_valid, out_ready,
    output in_ready, out_result, out_overflow, out_valid, busy
  );
endinterface

// File: rtl/iter_factorial_unit.sv
// Iterative n! engine, one multiply per cycle; out_valid n-1 cycles after accept (n<=1: next cycle).
// Result is held under out_ready=0; a new job is taken on the same edge the held result leaves.
module iter_factorial_unit #(
  parameter int N_WIDTH  = 8,
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  iter_factorial_unit_if.slave io
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [N_WIDTH-1:0]   cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  logic [WIDTH+N_WIDTH-1:0] prod;
  logic                     prod_hi_nz;
  logic                     accept;
  logic                     out_fire;

  // Full-width product so any bit above the accumulator flags overflow.
  assign prod       = {{N_WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, cnt_q};
  assign prod_hi_nz = |prod[WIDTH+N_WIDTH-1:WIDTH];

  assign io.in_ready = !rst && ((state_q == IDLE) || ((state_q == DONE) && io.out_ready));
  assign accept      = io.in_valid && io.in_ready;
  assign out_fire    = (state_q == DONE) && io.out_ready;

  assign io.out_valid    = (state_q == DONE);
  assign io.busy         = (state_q != IDLE);
  assign io.out_result   = (SATURATE && ovf_q) ? {WIDTH{1'b1}} : acc_q;
  assign io.out_overflow = ovf_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    case (state_q)
      RUN: begin
        acc_d = prod[WIDTH-1:0];
        ovf_d = ovf_q | prod_hi_nz;
        cnt_d = cnt_q - N_WIDTH'(1);
        if ((cnt_q == N_WIDTH'(2)) || (SATURATE && prod_hi_nz)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_fire) begin
          state_d = IDLE;
        end
      end
      default: begin
      end
    endcase

    // Acceptance only happens in IDLE or in DONE while the result leaves, so it overrides.
    if (accept) begin
      acc_d   = WIDTH'(1);
      cnt_d   = io.in_n;
      ovf_d   = 1'b0;
      state_d = (io.in_n <= N_WIDTH'(1)) ? DONE : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_iter_factorial_unit.sv
// Drives three engines (8-bit wrap, 8-bit saturate, 16-bit wrap) with identical jobs.
module tb_iter_factorial_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] n_drv;
  logic       vld_drv;
  logic       rdy_drv;

  iter_factorial_unit_if #(.N_WIDTH(8), .WIDTH(8))  if_w  ();
  iter_factorial_unit_if #(.N_WIDTH(8), .WIDTH(8))  if_s  ();
  iter_factorial_unit_if #(.N_WIDTH(8), .WIDTH(16)) if_16 ();

  assign if_w.in_n      = n_drv;
  assign if_w.in_valid  = vld_drv;
  assign if_w.out_ready = rdy_drv;
  assign if_s.in_n      = n_drv;
  assign if_s.in_valid  = vld_drv;
  assign if_s.out_ready = rdy_drv;
  assign if_16.in_n      = n_drv;
  assign if_16.in_valid  = vld_drv;
  assign if_16.out_ready = rdy_drv;

  iter_factorial_unit #(.N_WIDTH(8), .WIDTH(8), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .io(if_w)
  );
  iter_factorial_unit #(.N_WIDTH(8), .WIDTH(8), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .io(if_s)
  );
  iter_factorial_unit #(.N_WIDTH(8), .WIDTH(16), .SATURATE(1'b0)) u_wide (
    .clk(clk), .rst(rst), .io(if_16)
  );

  // Latency counts clock edges after the accepting edge until out_valid is seen;
  // n<=1 results are already valid right after the accepting edge (0 edges).
  typedef struct {
    logic [7:0]  n;
    logic [7:0]  r_w;  logic o_w;  int l_w;
    logic [7:0]  r_s;  logic o_s;  int l_s;
    logic [15:0] r_16; logic o_16; int l_16;
  } vec_t;

  vec_t vecs [9];

  int tests = 0;
  int fails = 0;

  logic [15:0] got_res [3];
  logic        got_ovf [3];
  int          got_lat [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called #1 after a posedge with all engines idle; returns with out_ready still high.
  task automatic run_job(input logic [7:0] n);
    logic [2:0] seen;
    n_drv   = n;
    vld_drv = 1'b1;
    rdy_drv = 1'b1;
    #1;
    check($sformatf("in_ready_idle n=%0d", n), {if_w.in_ready, if_s.in_ready, if_16.in_ready}, 3'b111);
    @(posedge clk); #1;
    vld_drv = 1'b0;
    n_drv   = ~n;
    seen    = 3'b000;
    for (int k = 0; k < 3; k++) begin
      got_res[k] = 16'hDEAD;
      got_ovf[k] = 1'bx;
      got_lat[k] = 999;
    end
    for (int c = 0; c < 300 && seen != 3'b111; c++) begin
      if (!seen[0] && if_w.out_valid) begin
        seen[0] = 1'b1; got_res[0] = {8'h00, if_w.out_result};  got_ovf[0] = if_w.out_overflow;  got_lat[0] = c;
      end
      if (!seen[1] && if_s.out_valid) begin
        seen[1] = 1'b1; got_res[1] = {8'h00, if_s.out_result};  got_ovf[1] = if_s.out_overflow;  got_lat[1] = c;
      end
      if (!seen[2] && if_16.out_valid) begin
        seen[2] = 1'b1; got_res[2] = if_16.out_result;          got_ovf[2] = if_16.out_overflow; got_lat[2] = c;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        found;
    int          lat;
    int          stale;

    vecs[0] = '{8'd0,   8'h01, 1'b0, 0,   8'h01, 1'b0, 0, 16'h0001, 1'b0, 0};
    vecs[1] = '{8'd1,   8'h01, 1'b0, 0,   8'h01, 1'b0, 0, 16'h0001, 1'b0, 0};
    vecs[2] = '{8'd2,   8'h02, 1'b0, 1,   8'h02, 1'b0, 1, 16'h0002, 1'b0, 1};
    vecs[3] = '{8'd5,   8'h78, 1'b0, 4,   8'h78, 1'b0, 4, 16'h0078, 1'b0, 4};
    vecs[4] = '{8'd6,   8'hD0, 1'b1, 5,   8'hFF, 1'b1, 4, 16'h02D0, 1'b0, 5};
    vecs[5] = '{8'd7,   8'hB0, 1'b1, 6,   8'hFF, 1'b1, 4, 16'h13B0, 1'b0, 6};
    vecs[6] = '{8'd8,   8'h80, 1'b1, 7,   8'hFF, 1'b1, 3, 16'h9D80, 1'b0, 7};
    vecs[7] = '{8'd9,   8'h80, 1'b1, 8,   8'hFF, 1'b1, 3, 16'h8980, 1'b1, 8};
    vecs[8] = '{8'd255, 8'h00, 1'b1, 254, 8'hFF, 1'b1, 2, 16'h0000, 1'b1, 254};

    rst = 1'b1; n_drv = 8'h00; vld_drv = 1'b0; rdy_drv = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst out_valid",    {if_w.out_valid, if_s.out_valid, if_16.out_valid}, 3'b000);
    check("rst out_overflow", {if_w.out_overflow, if_s.out_overflow, if_16.out_overflow}, 3'b000);
    check("rst busy",         {if_w.busy, if_s.busy, if_16.busy}, 3'b000);
    check("rst in_ready",     {if_w.in_ready, if_s.in_ready, if_16.in_ready}, 3'b000);
    check("rst result",       {if_w.out_result, if_s.out_result, if_16.out_result}, 32'h0);
    rst = 1'b0;
    #1;
    check("post-rst in_ready", {if_w.in_ready, if_s.in_ready, if_16.in_ready}, 3'b111);
    @(posedge clk); #1;

    for (int v = 0; v < 9; v++) begin
      run_job(vecs[v].n);
      check($sformatf("n=%0d wrap result", vecs[v].n), got_res[0], {8'h00, vecs[v].r_w});
      check($sformatf("n=%0d wrap ovf",    vecs[v].n), got_ovf[0], vecs[v].o_w);
      check($sformatf("n=%0d wrap lat",    vecs[v].n), got_lat[0], vecs[v].l_w);
      check($sformatf("n=%0d sat result",  vecs[v].n), got_res[1], {8'h00, vecs[v].r_s});
      check($sformatf("n=%0d sat ovf",     vecs[v].n), got_ovf[1], vecs[v].o_s);
      check($sformatf("n=%0d sat lat",     vecs[v].n), got_lat[1], vecs[v].l_s);
      check($sformatf("n=%0d w16 result",  vecs[v].n), got_res[2], vecs[v].r_16);
      check($sformatf("n=%0d w16 ovf",     vecs[v].n), got_ovf[2], vecs[v].o_16);
      check($sformatf("n=%0d w16 lat",     vecs[v].n), got_lat[2], vecs[v].l_16);
      check($sformatf("n=%0d valid pulse", vecs[v].n), {if_w.out_valid, if_s.out_valid, if_16.out_valid}, 3'b000);
      check($sformatf("n=%0d idle busy",   vecs[v].n), {if_w.busy, if_s.busy, if_16.busy}, 3'b000);
    end

    // Backpressure: hold the n=4 result, then hand off to n=3 on the same edge.
    n_drv = 8'd4; vld_drv = 1'b1; rdy_drv = 1'b0;
    @(posedge clk); #1;
    vld_drv = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (if_w.out_valid) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("bp result appears", found, 1'b1);
    n_drv = 8'd3; vld_drv = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp hold%0d result", k), if_w.out_result, 8'h18);
      check($sformatf("bp hold%0d w16",    k), if_16.out_result, 16'h0018);
      check($sformatf("bp hold%0d valid",  k), if_w.out_valid, 1'b1);
      check($sformatf("bp hold%0d in_rdy", k), {if_w.in_ready, if_s.in_ready, if_16.in_ready}, 3'b000);
      @(posedge clk); #1;
    end
    rdy_drv = 1'b1;
    #1;
    check("bp handoff in_ready", {if_w.in_ready, if_s.in_ready, if_16.in_ready}, 3'b111);
    @(posedge clk); #1;
    vld_drv = 1'b0; n_drv = 8'd9;
    check("bp handoff valid low", if_w.out_valid, 1'b0);
    check("bp handoff busy",      if_w.busy, 1'b1);
    lat = 999;
    for (int c = 0; c < 20 && lat == 999; c++) begin
      if (if_w.out_valid) lat = c;
      else begin
        @(posedge clk); #1;
      end
    end
    check("bp second lat",    lat, 2);
    check("bp second result", if_w.out_result, 8'h06);
    check("bp second w16",    if_16.out_result, 16'h0006);
    @(posedge clk); #1;

    // Reset two cycles into an n=7 job: job discarded, nothing emitted.
    n_drv = 8'd7; vld_drv = 1'b1; rdy_drv = 1'b1;
    @(posedge clk); #1;
    vld_drv = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid busy before rst", if_w.busy, 1'b1);
    rst = 1'b1;
    #1;
    check("mid rst in_ready", {if_w.in_ready, if_s.in_ready, if_16.in_ready}, 3'b000);
    @(posedge clk); #1;
    check("mid rst valid",  {if_w.out_valid, if_s.out_valid, if_16.out_valid}, 3'b000);
    check("mid rst busy",   {if_w.busy, if_s.busy, if_16.busy}, 3'b000);
    check("mid rst ovf",    {if_w.out_overflow, if_s.out_overflow, if_16.out_overflow}, 3'b000);
    check("mid rst result", {if_w.out_result, if_s.out_result, if_16.out_result}, 32'h0);
    rst = 1'b0;
    stale = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (if_w.out_valid || if_s.out_valid || if_16.out_valid) stale++;
    end
    check("no stale result", stale, 0);
    run_job(8'd3);
    check("after rst wrap result", got_res[0], 16'h0006);
    check("after rst sat result",  got_res[1], 16'h0006);
    check("after rst w16 result",  got_res[2], 16'h0006);
    check("after rst lat",         got_lat[0], 2);
    check("after rst ovf",         {got_ovf[0], got_ovf[1], got_ovf[2]}, 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
